// File: rtl/uart_sim_agent_if.sv
// Bus bundle for uart_sim_agent: send queue handshake, serial lines and receive report.
// The master side is the environment driving the agent; the slave side is the agent itself.
interface uart_sim_agent_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 send_valid;
   logic                 send_ready;
   logic [DATA_BITS-1:0] send_data;
   logic                 uart_to_dut;
   logic                 uart_from_dut;
   logic                 tx_busy;
   logic                 recv_valid;
   logic [DATA_BITS-1:0] recv_data;
   logic                 recv_parity_err;
   logic                 recv_frame_err;
   logic [15:0]          rx_count;

   modport master (
      output send_valid, send_data, uart_from_dut,
      input  send_ready, uart_to_dut, tx_busy, recv_valid, recv_data,
             recv_parity_err, recv_frame_err, rx_count
   );

   modport slave (
      input  send_valid, send_data, uart_from_dut,
      output send_ready, uart_to_dut, tx_busy, recv_valid, recv_data,
             recv_parity_err, recv_frame_err, rx_count
   );
endinterface

// File: rtl/uart_sim_agent.sv
// UART agent: queued transmitter driving the DUT's rx pin and a checking receiver
// on the DUT's tx pin; TX and RX run independently.
module uart_sim_agent #(
   parameter int unsigned CLKS_PER_BIT  = 217,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned PARITY        = 0,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned TX_FIFO_DEPTH = 16
) (
   input  logic           clock,
   input  logic           reset,
   uart_sim_agent_if.slave bus
);
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW   = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [CNTW-1:0] FULL      = CNTW'(TX_FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

   logic [DATA_BITS-1:0] mem_q [TX_FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 push, pop;

   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_clk_q, tx_clk_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_line_q, tx_line_d;
   logic                 tx_bit_end;

   logic                 sync1_q, sync2_q, prev_q;
   rx_state_e            rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_clk_q, rx_clk_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 valid_q, valid_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [15:0]          count_q, count_d;
   logic                 rx_bit_end;

   assign push = bus.send_valid && bus.send_ready;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= bus.send_data;
   end

   // The line flop is fed from the current state, so every bit appears one cycle after its state.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = 1'b1;
      pop        = 1'b0;
      tx_bit_end = (tx_clk_q == BIT_LAST);
      tx_clk_d   = tx_bit_end ? '0 : tx_clk_q + 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            tx_clk_d = '0;
            if (cnt_q != '0) begin
               pop        = 1'b1;
               tx_sh_d    = mem_q[rd_ptr_q];
               tx_par_d   = (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            tx_line_d = 1'b0;
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            tx_line_d = tx_sh_q[0];
            if (tx_bit_end) begin
               tx_sh_d = tx_sh_q >> 1;
               if (tx_bit_q == DATA_LAST) begin
                  tx_bit_d   = '0;
                  tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         TX_PARITY: begin
            tx_line_d = tx_par_q;
            if (tx_bit_end) tx_state_d = TX_STOP;
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bit_q == STOP_LAST) begin
                  tx_bit_d   = '0;
                  tx_state_d = TX_IDLE;
                  if (cnt_q != '0) begin
                     pop        = 1'b1;
                     tx_sh_d    = mem_q[rd_ptr_q];
                     tx_par_d   = (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
                     tx_state_d = TX_START;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Bit centres are reached by a half-bit wait in START, then whole bits from there on.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_perr_d  = rx_perr_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      count_d    = count_q;
      rx_bit_end = (rx_clk_q == BIT_LAST);
      rx_clk_d   = rx_bit_end ? '0 : rx_clk_q + 1'b1;
      case (rx_state_q)
         RX_IDLE: begin
            rx_clk_d = '0;
            if (prev_q && !sync2_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_clk_q == HALF_LAST) begin
               rx_clk_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_sh_d = {sync2_q, rx_sh_q[DATA_BITS-1:1]};
               if (rx_bit_q == DATA_LAST) begin
                  rx_bit_d   = '0;
                  rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_bit_end) begin
               rx_perr_d  = sync2_q != ((PARITY == 1) ? ~^rx_sh_q : ^rx_sh_q);
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_bit_end) begin
               valid_d    = 1'b1;
               data_d     = rx_sh_q;
               perr_d     = (PARITY != 0) && rx_perr_q;
               ferr_d     = !sync2_q;
               count_d    = count_q + 16'd1;
               rx_state_d = sync2_q ? RX_IDLE : RX_WAIT_IDLE;
            end
         end
         RX_WAIT_IDLE: begin
            rx_clk_d = '0;
            if (sync2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         tx_state_q <= TX_IDLE;
         tx_clk_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_clk_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_perr_q  <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         tx_state_q <= tx_state_d;
         tx_clk_q   <= tx_clk_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
         sync1_q    <= bus.uart_from_dut;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_clk_q   <= rx_clk_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_perr_q  <= rx_perr_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         count_q    <= count_d;
      end
   end

   assign bus.send_ready      = (cnt_q != FULL);
   assign bus.tx_busy         = (cnt_q != '0) || (tx_state_q != TX_IDLE);
   assign bus.uart_to_dut     = tx_line_q;
   assign bus.recv_valid      = valid_q;
   assign bus.recv_data       = data_q;
   assign bus.recv_parity_err = perr_q;
   assign bus.recv_frame_err  = ferr_q;
   assign bus.rx_count        = count_q;
endmodule

// File: tb/tb_uart_sim_agent.sv
// Scoreboard bench for uart_sim_agent: loopback and bench-driven frames, even parity, CLKS_PER_BIT=4.
module tb_uart_sim_agent;
   localparam int unsigned CPB   = 4;
   localparam int unsigned DB    = 8;
   localparam int unsigned PAR   = 2;
   localparam int unsigned SB    = 1;
   localparam int unsigned DEPTH = 16;
   localparam int FRAME_CLKS = (2 + DB + SB) * CPB;

   typedef struct {
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   logic loop_en;
   logic drv_line;

   uart_sim_agent_if #(.DATA_BITS(DB)) bus();
   assign bus.uart_from_dut = loop_en ? bus.uart_to_dut : drv_line;

   uart_sim_agent #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .TX_FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clock = ~clock;

   int     n_checks = 0;
   int     n_pass   = 0;
   longint cyc      = 0;
   longint last_cyc = -1;
   int     exp_cnt  = 0;
   bit     gap_chk  = 1'b0;
   exp_t   exp_q[$];

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Monitor: every received frame is matched against the oldest expectation.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset) begin
         exp_q.delete();
         exp_cnt  = 0;
         last_cyc = -1;
      end else if (bus.recv_valid) begin
         exp_cnt = (exp_cnt + 1) % 65536;
         chk("rx_count", 32'(bus.rx_count), 32'(exp_cnt));
         if (exp_q.size() == 0) begin
            chk("unexpected_recv_valid", 32'(bus.recv_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("recv_data", 32'(bus.recv_data), 32'(e.data));
            chk("recv_parity_err", 32'(bus.recv_parity_err), 32'(e.perr));
            chk("recv_frame_err", 32'(bus.recv_frame_err), 32'(e.ferr));
         end
         if (gap_chk) begin
            if (last_cyc >= 0) chk("frame_gap", 32'(cyc - last_cyc), 32'(FRAME_CLKS));
            last_cyc = cyc;
         end
      end
   end

   function automatic exp_t mk(input logic [DB-1:0] d, input logic pe, input logic fe);
      exp_t e;
      e.data = d;
      e.perr = pe;
      e.ferr = fe;
      return e;
   endfunction

   task automatic send_bit(input logic b);
      drv_line = b;
      repeat (CPB) @(negedge clock);
   endtask

   // Even parity: the parity bit makes the total count of ones even.
   task automatic drive_frame(input logic [DB-1:0] d, input bit bad_par, input int stop_low);
      int ones = 0;
      for (int i = 0; i < DB; i++) ones += int'(d[i]);
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(d[i]);
      send_bit(((ones % 2) == 1) ^ bad_par);
      for (int k = 0; k < stop_low; k++) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int i = 0;
      while ((exp_q.size() != 0 || bus.tx_busy) && i < budget) begin
         @(negedge clock);
         i++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic push_byte(input logic [DB-1:0] d);
      int g = 0;
      bus.send_valid = 1'b1;
      bus.send_data  = d;
      while (!bus.send_ready && g < 5000) begin
         @(negedge clock);
         g++;
      end
      exp_q.push_back(mk(d, 1'b0, 1'b0));
      @(negedge clock);
      bus.send_valid = 1'b0;
   endtask

   initial begin
      int d;
      int first_full;
      int guard;
      logic [DB-1:0] r;
      bit bad;
      int sl;

      reset          = 1'b1;
      loop_en        = 1'b1;
      drv_line       = 1'b1;
      bus.send_valid = 1'b0;
      bus.send_data  = '0;
      repeat (3) @(negedge clock);
      chk("rst_uart_to_dut", 32'(bus.uart_to_dut), 32'd1);
      chk("rst_send_ready", 32'(bus.send_ready), 32'd1);
      chk("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
      chk("rst_recv_valid", 32'(bus.recv_valid), 32'd0);
      chk("rst_recv_data", 32'(bus.recv_data), 32'd0);
      chk("rst_parity_err", 32'(bus.recv_parity_err), 32'd0);
      chk("rst_frame_err", 32'(bus.recv_frame_err), 32'd0);
      chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Single loopback byte and start-bit latency.
      bus.send_valid = 1'b1;
      bus.send_data  = 8'hA5;
      exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
      @(negedge clock);
      bus.send_valid = 1'b0;
      chk("line_after_push", 32'(bus.uart_to_dut), 32'd1);
      chk("busy_after_push", 32'(bus.tx_busy), 32'd1);
      @(negedge clock);
      chk("line_push_plus1", 32'(bus.uart_to_dut), 32'd1);
      @(negedge clock);
      chk("start_bit_push_plus2", 32'(bus.uart_to_dut), 32'd0);
      wait_drain("drain_single", 4 * FRAME_CLKS);
      chk("rx_count_single", 32'(bus.rx_count), 32'd1);

      // Burst 0x00..0x13 with valid held high.
      gap_chk    = 1'b1;
      last_cyc   = -1;
      d          = 0;
      first_full = -1;
      guard      = 0;
      bus.send_valid = 1'b1;
      while (d < 20 && guard < 5000) begin
         bus.send_data = 8'(d);
         if (bus.send_ready) begin
            exp_q.push_back(mk(8'(d), 1'b0, 1'b0));
            d++;
         end else if (first_full < 0) begin
            first_full = d;
         end
         @(negedge clock);
         guard++;
      end
      bus.send_valid = 1'b0;
      chk("pushes_until_full", 32'(first_full), 32'd17);
      wait_drain("drain_burst", 30 * FRAME_CLKS);
      gap_chk = 1'b0;
      chk("rx_count_burst", 32'(bus.rx_count), 32'd21);

      // Bench-driven frames: bad parity, break, clean follow-up.
      loop_en = 1'b0;
      exp_q.push_back(mk(8'h3C, 1'b1, 1'b0));
      drive_frame(8'h3C, 1'b1, 0);
      wait_drain("drain_bad_parity", 4 * FRAME_CLKS);
      exp_q.push_back(mk(8'h55, 1'b0, 1'b1));
      drive_frame(8'h55, 1'b0, 3);
      exp_q.push_back(mk(8'h12, 1'b0, 1'b0));
      drive_frame(8'h12, 1'b0, 0);
      wait_drain("drain_break", 4 * FRAME_CLKS);

      // Random driven frames with random parity and stop faults.
      repeat (12) begin
         r   = 8'($urandom);
         bad = 1'($urandom_range(0, 1));
         sl  = int'($urandom_range(0, 2));
         exp_q.push_back(mk(r, bad, sl > 0));
         drive_frame(r, bad, sl);
      end
      wait_drain("drain_random_rx", 4 * FRAME_CLKS);

      // Glitch rejection.
      drv_line = 1'b0;
      @(negedge clock);
      drv_line = 1'b1;
      repeat (4 * CPB) @(negedge clock);
      chk("glitch_rx_count", 32'(bus.rx_count), 32'(exp_cnt));

      // Random loopback bytes with random gaps.
      loop_en = 1'b1;
      repeat (10) begin
         push_byte(8'($urandom));
         repeat ($urandom_range(0, 30)) @(negedge clock);
      end
      wait_drain("drain_random_loop", 12 * FRAME_CLKS);

      // Reset in the middle of a frame with five bytes still queued.
      for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
      repeat (3 * CPB + 1) @(negedge clock);
      chk("busy_before_reset", 32'(bus.tx_busy), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_uart_to_dut", 32'(bus.uart_to_dut), 32'd1);
      chk("midrst_send_ready", 32'(bus.send_ready), 32'd1);
      chk("midrst_tx_busy", 32'(bus.tx_busy), 32'd0);
      chk("midrst_rx_count", 32'(bus.rx_count), 32'd0);
      chk("midrst_recv_valid", 32'(bus.recv_valid), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3 * FRAME_CLKS) @(negedge clock);
      chk("post_reset_tx_busy", 32'(bus.tx_busy), 32'd0);
      chk("post_reset_rx_count", 32'(bus.rx_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
